// File: rtl/plugboard_config.sv
// plugboard_config: builds and holds the 26-entry plugboard wiring map.
// Host commands (CLEAR / ADD / REMOVE) are checked against the current map
// before anything is written, so the published map is always an involution.
module plugboard_config #(
  parameter int MAX_PAIRS = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [4:0]   cmd_a,
  input  logic [4:0]   cmd_b,
  output logic         rsp_valid,
  output logic [2:0]   rsp_code,
  output logic [129:0] plug_map,
  output logic [3:0]   pair_count,
  output logic         busy
);

  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_REMOVE = 2'b11;

  localparam logic [2:0] RSP_OK          = 3'd0;
  localparam logic [2:0] RSP_RANGE       = 3'd1;
  localparam logic [2:0] RSP_SAME        = 3'd2;
  localparam logic [2:0] RSP_PLUGGED     = 3'd3;
  localparam logic [2:0] RSP_FULL        = 3'd4;
  localparam logic [2:0] RSP_NOT_PLUGGED = 3'd5;
  localparam logic [2:0] RSP_BAD_OP      = 3'd6;

  localparam logic [4:0] LAST_LETTER = 5'd25;
  localparam logic [3:0] MAX_PAIRS_C = 4'(MAX_PAIRS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_COMMIT = 3'd2,
    S_CLEAR  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_next_s;

  logic [4:0] map_r [26];
  logic [3:0] pair_count_r;
  logic       ready_r;
  logic       rsp_valid_r;
  logic [2:0] rsp_code_r;

  // Latched command and the result of the CHECK cycle.
  logic [1:0] op_r;
  logic [4:0] a_r;
  logic [4:0] b_r;
  logic [4:0] p_r;
  logic [2:0] code_r;
  logic [4:0] sweep_r;

  // Combinational check results.
  logic       a_in_s;
  logic       b_in_s;
  logic [4:0] map_a_s;
  logic [4:0] map_b_s;
  logic [2:0] check_code_s;

  assign cmd_ready  = ready_r;
  assign busy       = ~ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_code   = rsp_code_r;
  assign pair_count = pair_count_r;

  // Flatten the map array onto the published 130-bit bus.
  always_comb begin
    plug_map = '0;
    for (int i = 0; i < 26; i++) begin
      plug_map[5*i +: 5] = map_r[i];
    end
  end

  // Next-state selection for the command sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_CLEAR) begin
            state_next_s = S_CLEAR;
          end else begin
            state_next_s = S_CHECK;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CHECK:  state_next_s = S_COMMIT;
      S_COMMIT: state_next_s = S_RESP;
      S_CLEAR: begin
        if (sweep_r == LAST_LETTER) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_CLEAR;
        end
      end
      S_RESP:   state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Range/conflict evaluation of the latched command; out-of-range letters
  // never index the map (they read back as themselves).
  always_comb begin
    a_in_s       = (a_r <= LAST_LETTER);
    b_in_s       = (b_r <= LAST_LETTER);
    map_a_s      = a_r;
    map_b_s      = b_r;
    check_code_s = RSP_OK;
    if (a_in_s) begin
      map_a_s = map_r[a_r];
    end else begin
      map_a_s = a_r;
    end
    if (b_in_s) begin
      map_b_s = map_r[b_r];
    end else begin
      map_b_s = b_r;
    end
    case (op_r)
      OP_ADD: begin
        if (!a_in_s || !b_in_s) begin
          check_code_s = RSP_RANGE;
        end else if (a_r == b_r) begin
          check_code_s = RSP_SAME;
        end else if ((map_a_s != a_r) || (map_b_s != b_r)) begin
          check_code_s = RSP_PLUGGED;
        end else if (pair_count_r == MAX_PAIRS_C) begin
          check_code_s = RSP_FULL;
        end else begin
          check_code_s = RSP_OK;
        end
      end
      OP_REMOVE: begin
        if (!a_in_s) begin
          check_code_s = RSP_RANGE;
        end else if (map_a_s == a_r) begin
          check_code_s = RSP_NOT_PLUGGED;
        end else begin
          check_code_s = RSP_OK;
        end
      end
      default: check_code_s = RSP_BAD_OP;
    endcase
  end

  // State, map, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      for (int i = 0; i < 26; i++) begin
        map_r[i] <= 5'(i);
      end
      pair_count_r <= 4'd0;
      ready_r      <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_code_r   <= RSP_OK;
      op_r         <= 2'b00;
      a_r          <= 5'd0;
      b_r          <= 5'd0;
      p_r          <= 5'd0;
      code_r       <= RSP_OK;
      sweep_r      <= 5'd0;
    end else begin
      state_r     <= state_next_s;
      ready_r     <= (state_next_s == S_IDLE);
      rsp_valid_r <= (state_next_s == S_RESP);
      case (state_r)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r    <= cmd_op;
            a_r     <= cmd_a;
            b_r     <= cmd_b;
            sweep_r <= 5'd0;
          end
        end
        S_CHECK: begin
          code_r <= check_code_s;
          p_r    <= map_a_s;
        end
        S_COMMIT: begin
          rsp_code_r <= code_r;
          if (code_r == RSP_OK) begin
            if (op_r == OP_ADD) begin
              map_r[a_r]   <= b_r;
              map_r[b_r]   <= a_r;
              pair_count_r <= pair_count_r + 4'd1;
            end else if (op_r == OP_REMOVE) begin
              map_r[a_r]   <= a_r;
              map_r[p_r]   <= p_r;
              pair_count_r <= pair_count_r - 4'd1;
            end
          end
        end
        S_CLEAR: begin
          map_r[sweep_r] <= sweep_r;
          sweep_r        <= sweep_r + 5'd1;
          if (sweep_r == LAST_LETTER) begin
            pair_count_r <= 4'd0;
            rsp_code_r   <= RSP_OK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_plugboard_config.sv
// Self-checking bench for plugboard_config: directed table, corner-case
// sequences (CLEAR timing, reset mid-sweep) and a random command stream
// checked against a letter-array reference model.
module tb_plugboard_config;

  localparam int MAXP = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [4:0]   cmd_a;
  logic [4:0]   cmd_b;
  logic         rsp_valid;
  logic [2:0]   rsp_code;
  logic [129:0] plug_map;
  logic [3:0]   pair_count;
  logic         busy;

  always #5 clk = ~clk;

  plugboard_config #(.MAX_PAIRS(MAXP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
    .rsp_code(rsp_code), .plug_map(plug_map), .pair_count(pair_count),
    .busy(busy)
  );

  int vectors     = 0;
  int miscompares = 0;
  int m [26];

  typedef struct {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] code;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_identity();
    for (int x = 0; x < 26; x++) m[x] = x;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int x = 0; x < 26; x++) if (m[x] > x) n++;
    return n;
  endfunction

  function automatic logic [129:0] model_map();
    logic [129:0] v = '0;
    for (int x = 0; x < 26; x++) v[5*x +: 5] = 5'(m[x]);
    return v;
  endfunction

  function automatic logic [2:0] model_apply(input logic [1:0] op, input logic [4:0] a5, input logic [4:0] b5);
    int a = int'(a5);
    int b = int'(b5);
    int p;
    case (op)
      2'b01: begin
        for (int x = 0; x < 26; x++) m[x] = x;
        return 3'd0;
      end
      2'b10: begin
        if (a > 25 || b > 25) return 3'd1;
        if (a == b) return 3'd2;
        if (m[a] != a || m[b] != b) return 3'd3;
        if (model_count() == MAXP) return 3'd4;
        m[a] = b;
        m[b] = a;
        return 3'd0;
      end
      2'b11: begin
        if (a > 25) return 3'd1;
        p = m[a];
        if (p == a) return 3'd5;
        m[a] = a;
        m[p] = p;
        return 3'd0;
      end
      default: return 3'd6;
    endcase
  endfunction

  // ---------------- DUT observation helpers ----------------
  function automatic int dut_entry(input int x);
    return int'(plug_map[5*x +: 5]);
  endfunction

  task automatic check_idle();
    logic ok = 1'b1;
    int   n  = 0;
    int   y;
    for (int x = 0; x < 26; x++) begin
      y = dut_entry(x);
      if (y > 25) ok = 1'b0;
      else if (dut_entry(y) != x) ok = 1'b0;
      if (y > x) n++;
    end
    chk("involution", 130'(ok), 130'd1);
    chk("pair_invariant", 130'(pair_count), 130'(n));
  endtask

  // Issue one command; returns response code, edges from accept to the
  // response sample, and number of busy samples seen in that window.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         output logic [2:0] code, output int lat, output int busy_n);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_timeout", 130'(guard < 100), 130'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a = 5'($urandom); cmd_b = 5'($urandom);
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (!rsp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    code = rsp_code;
  endtask

  // Compare the response and resulting state, then confirm the pulse ends.
  task automatic post_cmd(input logic [2:0] exp_code, input int exp_lat,
                          input logic [2:0] code, input int lat);
    chk("rsp_code", 130'(code), 130'(exp_code));
    chk("latency", 130'(lat), 130'(exp_lat));
    chk("plug_map", plug_map, model_map());
    chk("pair_count", 130'(pair_count), 130'(model_count()));
    @(posedge clk); #1;
    chk("rsp_pulse_end", 130'(rsp_valid), 130'd0);
    chk("ready_after", 130'(cmd_ready), 130'd1);
    check_idle();
  endtask

  initial begin
    logic [2:0] code;
    logic [2:0] exp;
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    int         lat;
    int         busy_n;
    int         seen;
    int         r;

    // Directed table
    tbl[0]  = '{2'b10, 5'd0,  5'd1,  3'd0};
    tbl[1]  = '{2'b10, 5'd1,  5'd5,  3'd3};
    tbl[2]  = '{2'b10, 5'd26, 5'd26, 3'd1};
    tbl[3]  = '{2'b10, 5'd7,  5'd7,  3'd2};
    tbl[4]  = '{2'b00, 5'd3,  5'd4,  3'd6};
    tbl[5]  = '{2'b11, 5'd9,  5'd0,  3'd5};
    for (int k = 1; k <= 9; k++) tbl[5+k] = '{2'b10, 5'(2*k), 5'(2*k+1), 3'd0};
    tbl[15] = '{2'b10, 5'd20, 5'd21, 3'd4};
    tbl[16] = '{2'b11, 5'd19, 5'd3,  3'd0};
    tbl[17] = '{2'b10, 5'd18, 5'd19, 3'd0};

    // Reset
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 5'd0; cmd_b = 5'd0;
    model_identity();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_map", plug_map, model_map());
    chk("reset_pairs", 130'(pair_count), 130'd0);
    chk("reset_ready", 130'(cmd_ready), 130'd1);
    chk("reset_busy", 130'(busy), 130'd0);
    chk("reset_rsp_valid", 130'(rsp_valid), 130'd0);
    chk("reset_rsp_code", 130'(rsp_code), 130'd0);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      exp = model_apply(tbl[i].op, tbl[i].a, tbl[i].b);
      run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, code, lat, busy_n);
      post_cmd(tbl[i].code, 2, code, lat);
    end
    chk("ten_pairs", 130'(pair_count), 130'd10);

    // CLEAR with 10 pairs: 27 busy cycles, response 26 edges after accept
    exp = model_apply(2'b01, 5'd0, 5'd0);
    run_cmd(2'b01, 5'd0, 5'd0, code, lat, busy_n);
    chk("clear_busy_cycles", 130'(busy_n), 130'd27);
    post_cmd(3'd0, 26, code, lat);

    // Second CLEAR interrupted by reset at accept+10
    exp = model_apply(2'b10, 5'd20, 5'd21);
    run_cmd(2'b10, 5'd20, 5'd21, code, lat, busy_n);
    post_cmd(exp, 2, code, lat);
    exp = model_apply(2'b10, 5'd24, 5'd25);
    run_cmd(2'b10, 5'd24, 5'd25, code, lat, busy_n);
    post_cmd(exp, 2, code, lat);
    cmd_op = 2'b01; cmd_a = 5'd0; cmd_b = 5'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_identity();
    chk("abort_rsp_valid", 130'(rsp_valid), 130'd0);
    chk("abort_ready", 130'(cmd_ready), 130'd1);
    chk("abort_map", plug_map, model_map());
    chk("abort_pairs", 130'(pair_count), 130'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 130'(seen), 130'd0);
    check_idle();

    // Random command stream against the model
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       op = 2'b01;
      else if (r < 55) op = 2'b10;
      else if (r < 95) op = 2'b11;
      else             op = 2'b00;
      a = 5'($urandom_range(0, 27));
      b = 5'($urandom_range(0, 27));
      exp = model_apply(op, a, b);
      run_cmd(op, a, b, code, lat, busy_n);
      post_cmd(exp, (op == 2'b01) ? 26 : 2, code, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/plugboard_config.md
# plugboard_config

Sequential configuration engine that builds and holds the 130-bit Steckerbrett wiring map consumed by both plugboard lookup instances. Host commands (add pair, remove pair, clear) arrive over a valid/ready handshake. Each command is range- and conflict-checked before commit, so the published map is always a reciprocal involution: for every x, map[map[x]] = x. The block sits between the host/UI command decoder and the enigma_forward/enigma_backward plugboard instances.

## Interface
- MAX_PAIRS, 13, maximum simultaneous plug pairs (range 1..13; 10 for historical Enigma I key sheets)
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 = reserved, 01 = CLEAR, 10 = ADD, 11 = REMOVE
- cmd_a  in  5  first letter index
- cmd_b  in  5  second letter index (ADD only; ignored otherwise)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_code  out  3  0 OK, 1 RANGE, 2 SAME, 3 PLUGGED, 4 FULL, 5 NOT_PLUGGED, 6 BAD_OP
- plug_map  out  130  entry x in bits [5x+4:5x]; identity when unplugged
- pair_count  out  4  number of active pairs
- busy  out  1  equals !cmd_ready; the map must not be used for encryption while high

## Operation
- States: IDLE, CHECK, COMMIT, CLEAR, RESP.
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_op, cmd_a and cmd_b are latched at acceptance; inputs are don't-care afterwards.
- IDLE -> CHECK for ADD, REMOVE or reserved. IDLE -> CLEAR for CLEAR.
- CHECK for ADD: read map[a] and map[b]. Error priority:
  - RANGE if a > 25 or b > 25
  - SAME if a == b
  - PLUGGED if map[a] != a or map[b] != b
  - FULL if pair_count == MAX_PAIRS
- CHECK for REMOVE: p = map[a]. RANGE if a > 25; NOT_PLUGGED if p == a.
- Reserved op: code BAD_OP. No read is performed.
- CHECK -> COMMIT.
- COMMIT:
  - ADD OK: write map[a] = b and map[b] = a, pair_count + 1.
  - REMOVE OK: write map[a] = a and map[p] = p, pair_count - 1.
  - On any error, nothing is written.
  - COMMIT -> RESP.
- CLEAR: a 5-bit sweep index runs 0..25, writing map[i] = i, one entry per cycle. pair_count is set to 0 on the last write, then CLEAR -> RESP with code OK. CLEAR never errors.
- RESP: rsp_valid = 1 with the registered rsp_code. RESP -> IDLE.
- Invariant at every IDLE cycle: map is an involution and pair_count equals the number of x with map[x] > x.
- pair_count is never incremented past MAX_PAIRS and never decremented below 0.

## Timing
- Reset (rst high at an edge) produces, on the next cycle:
  - plug_map = identity (entry x = x)
  - pair_count = 0, state IDLE
  - cmd_ready = 1, busy = 0
  - rsp_valid = 0, rsp_code = 0
- Reset mid-command aborts the command: no response, map forced to identity, including during a CLEAR sweep.
- ADD/REMOVE/reserved accepted at edge T:
  - CHECK during cycle T+1, COMMIT during T+2.
  - RESP during T+3: rsp_valid = 1, updated plug_map visible, cmd_ready = 0.
  - IDLE at T+4: next command can be accepted at edge T+4.
  - Sustained throughput is one command per 4 cycles.
- CLEAR accepted at edge T:
  - Writes occur in cycles T+1..T+26.
  - RESP during T+27; accept possible at edge T+28.
  - During the sweep plug_map is partially cleared and busy = 1.
- plug_map changes only at the COMMIT edge or a CLEAR sweep edge. It is stable whenever busy = 0.
- The rsp_valid pulse is exactly one cycle. There is no rsp_ready; the host must sample it.

## Test plan
- Reset then idle -> plug_map entry x = x for all 26 entries, pair_count 0, cmd_ready 1, rsp_valid 0.
- ADD(0,1) accepted at T -> rsp_valid at T+3 with code 0; entry0 = 1, entry1 = 0, pair_count 1. A following ADD(1,5) -> code 3 (PLUGGED), map unchanged.
- Error priority:
  - ADD(26,26) -> code 1 (RANGE).
  - ADD(7,7) -> code 2 (SAME).
  - op 00 -> code 6 (BAD_OP).
  - REMOVE(9) on an unplugged letter -> code 5 (NOT_PLUGGED).
  - No map change in any of these cases.
- With MAX_PAIRS = 10: add 10 disjoint pairs (0-1 .. 18-19) -> all code 0, pair_count 10. ADD(20,21) -> code 4 (FULL). REMOVE(19) -> entries 18 and 19 become identity, pair_count 9.
- CLEAR with 10 pairs set -> busy for 27 cycles, rsp_valid at T+27, identity map, pair_count 0. Assert rst at T+10 of a second CLEAR -> no rsp_valid, identity map, IDLE next cycle.
- Random command stream of 2000 commands vs. reference model -> map involution and pair_count invariant hold at every IDLE cycle, and every rsp_code matches the model.
